// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between two requesters and the logic unit arbiter.
// master = requester side, slave = arbiter side.
interface logic_unit_arbiter_if;
   logic        req0;
   logic        req1;
   logic [2:0]  op0;
   logic [2:0]  op1;
   logic [31:0] a0;
   logic [31:0] b0;
   logic [31:0] a1;
   logic [31:0] b1;
   logic        ack0;
   logic        ack1;
   logic [31:0] result;
   logic        busy;
   logic [7:0]  op_cnt;

   modport master (
      output req0, req1, op0, op1, a0, b0, a1, b1,
      input  ack0, ack1, result, busy, op_cnt
   );

   modport slave (
      input  req0, req1, op0, op1, a0, b0, a1, b1,
      output ack0, ack1, result, busy, op_cnt
   );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of a 32-bit bitwise logic unit (IDLE -> EXEC -> RESP).
// Define LOGIC_UNIT_ARBITER_FIXED_PRI_EN for fixed priority (requester 0 wins); default is round-robin.
module logic_unit_arbiter (
   input  logic                 clk,
   input  logic                 reset,
   logic_unit_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      EXEC    = 2'b01,
      RESP    = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [2:0]  lat_op;
   logic [31:0] lat_a;
   logic [31:0] lat_b;
   logic        lat_id;
   logic [31:0] result_q;
   logic [7:0]  op_cnt_q;

   logic        any_req;
   logic        grant_id;
   logic        latch_en;
   logic [31:0] alu_out;
   logic        ack0_c;
   logic        ack1_c;
   logic        busy_c;

   function automatic logic [31:0] logic_fn(
      input logic [2:0]  op,
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [31:0] r;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~(a ^ b);
         3'b100:  r = ~(a & b);
         3'b101:  r = ~(a | b);
         3'b110:  r = ~a;
         default: r = a;
      endcase
      return r;
   endfunction

   assign any_req  = bus.req0 | bus.req1;
   assign latch_en = (state == IDLE) && any_req;

`ifdef LOGIC_UNIT_ARBITER_FIXED_PRI_EN
   assign grant_id = ~bus.req0;
`else
   logic last_grant;

   // Under contention the requester that did not win last time goes first.
   always_comb begin
      grant_id = ~bus.req0;
      if (bus.req0 && bus.req1) begin
         grant_id = ~last_grant;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (latch_en) begin
         last_grant <= grant_id;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ack0_c    = 1'b0;
      ack1_c    = 1'b0;
      busy_c    = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            busy_c    = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            busy_c    = 1'b1;
            ack0_c    = ~lat_id;
            ack1_c    = lat_id;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign alu_out = logic_fn(lat_op, lat_a, lat_b);

   // Operands are captured once at grant so the loser's inputs cannot disturb the operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_op   <= 3'b000;
         lat_a    <= 32'h0;
         lat_b    <= 32'h0;
         lat_id   <= 1'b0;
         result_q <= 32'h0;
         op_cnt_q <= 8'h00;
      end else begin
         if (latch_en) begin
            lat_id <= grant_id;
            if (grant_id) begin
               lat_op <= bus.op1;
               lat_a  <= bus.a1;
               lat_b  <= bus.b1;
            end else begin
               lat_op <= bus.op0;
               lat_a  <= bus.a0;
               lat_b  <= bus.b0;
            end
         end
         if (state == EXEC) begin
            result_q <= alu_out;
         end
         if (state == RESP) begin
            op_cnt_q <= op_cnt_q + 8'd1;
         end
      end
   end

   assign bus.ack0   = ack0_c;
   assign bus.ack1   = ack1_c;
   assign bus.busy   = busy_c;
   assign bus.result = result_q;
   assign bus.op_cnt = op_cnt_q;

endmodule
